// File: rtl/tl_vc_arbiter_sm.sv
// Main FSM and round-robin VC arbiter: configures the FIFO bank and moves one word per cycle.
// Build macro PRIO_Q0_EN: queue 0 gets strict priority, queues 1..3 share a round-robin.
module tl_vc_arbiter_sm #(
    parameter int DATA_W   = 10,
    parameter int NUM_Q    = 4,
    parameter int UMBRAL_W = 3
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    init,
    input  logic [UMBRAL_W-1:0]     umbral_sup_in,
    input  logic [UMBRAL_W-1:0]     umbral_inf_in,
    input  logic [NUM_Q-1:0]        in_empty,
    input  logic [NUM_Q*DATA_W-1:0] in_data,
    input  logic [NUM_Q-1:0]        out_almost_full,
    output logic [3:0]              state,
    output logic [UMBRAL_W-1:0]     umbral_superior,
    output logic [UMBRAL_W-1:0]     umbral_inferior,
    output logic [NUM_Q-1:0]        pop,
    output logic [NUM_Q-1:0]        push,
    output logic [DATA_W-1:0]       data_out,
    output logic                    idle
);
    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;
    localparam int         QW        = 2;
`ifdef PRIO_Q0_EN
    localparam logic [QW-1:0] RR_RST = 2'd1;
`else
    localparam logic [QW-1:0] RR_RST = 2'd0;
`endif

    logic [QW-1:0]     rr_ptr_r;
    logic [QW-1:0]     pop_idx_r;
    logic [QW-1:0]     sel1_r;
    logic              v1_r;
    logic [3:0]        state_nxt_s;
    logic [NUM_Q-1:0]  req_s;
    logic [NUM_Q-1:0]  pop_nxt_s;
    logic [NUM_Q-1:0]  push_nxt_s;
    logic [QW:0]       pick_s;
    logic [QW-1:0]     grant_s;
    logic [QW-1:0]     rr_nxt_s;
    logic              grant_vld_s;
    logic              in_flight_s;
    logic              pop_ok_s;
    logic              idle_nxt_s;
    logic [DATA_W-1:0] rd_word_s;

    // Returns {found, index} of the first requesting queue starting at ptr.
    function automatic logic [QW:0] rr_pick(input logic [NUM_Q-1:0] req, input logic [QW-1:0] ptr);
        logic [QW:0]   res;
        logic [QW-1:0] idx;
        res = {1'b0, 2'd0};
`ifdef PRIO_Q0_EN
        idx = (ptr == 2'd0) ? 2'd1 : ptr;
        if (req[0]) begin
            res = {1'b1, 2'd0};
        end else begin
            for (int k = 0; k < NUM_Q - 1; k++) begin
                res = (!res[QW] && req[idx]) ? {1'b1, idx} : res;
                idx = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
            end
        end
`else
        for (int k = 0; k < NUM_Q; k++) begin
            idx = ptr + k[QW-1:0];
            res = (!res[QW] && req[idx]) ? {1'b1, idx} : res;
        end
`endif
        return res;
    endfunction

    // Next-state, grant and pipeline decode.
    always_comb begin
        req_s       = ~in_empty;
        in_flight_s = (pop != '0) | v1_r;
        state_nxt_s = state;
        case (state)
            ST_RESET:  state_nxt_s = ST_INIT;
            ST_INIT:   state_nxt_s = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (init && !in_flight_s)       state_nxt_s = ST_INIT;
                else if (req_s != '0)           state_nxt_s = ST_ACTIVE;
                else                            state_nxt_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (init && !in_flight_s)                    state_nxt_s = ST_INIT;
                else if ((req_s == '0) && !in_flight_s)      state_nxt_s = ST_IDLE;
                else                                         state_nxt_s = ST_ACTIVE;
            end
            default:   state_nxt_s = ST_RESET;
        endcase

        // Destination is unknown until the word is read, so any almost_full blocks all pops.
        pop_ok_s    = (state_nxt_s == ST_ACTIVE) && !init && (out_almost_full == '0);
        pick_s      = rr_pick(req_s, rr_ptr_r);
        grant_vld_s = pick_s[QW];
        grant_s     = pick_s[QW-1:0];
`ifdef PRIO_Q0_EN
        if (grant_s == 2'd0)      rr_nxt_s = rr_ptr_r;
        else if (grant_s == 2'd3) rr_nxt_s = 2'd1;
        else                      rr_nxt_s = grant_s + 2'd1;
`else
        rr_nxt_s = grant_s + 2'd1;
`endif

        case (sel1_r)
            2'd0:    rd_word_s = in_data[0*DATA_W +: DATA_W];
            2'd1:    rd_word_s = in_data[1*DATA_W +: DATA_W];
            2'd2:    rd_word_s = in_data[2*DATA_W +: DATA_W];
            2'd3:    rd_word_s = in_data[3*DATA_W +: DATA_W];
            default: rd_word_s = '0;
        endcase

        for (int i = 0; i < NUM_Q; i++) begin
            pop_nxt_s[i]  = pop_ok_s && grant_vld_s && (grant_s == i[QW-1:0]);
            push_nxt_s[i] = v1_r && (rd_word_s[DATA_W-1 -: QW] == i[QW-1:0]);
        end
        idle_nxt_s = (state_nxt_s == ST_IDLE) && !in_flight_s && (pop_nxt_s == '0);
    end

    // Registered outputs, two-stage pop-to-push pipeline and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state           <= ST_RESET;
            pop             <= '0;
            push            <= '0;
            data_out        <= '0;
            umbral_superior <= '0;
            umbral_inferior <= '0;
            idle            <= 1'b0;
            rr_ptr_r        <= RR_RST;
            pop_idx_r       <= 2'd0;
            sel1_r          <= 2'd0;
            v1_r            <= 1'b0;
        end else begin
            state     <= state_nxt_s;
            pop       <= pop_nxt_s;
            push      <= push_nxt_s;
            idle      <= idle_nxt_s;
            v1_r      <= (pop != '0);
            sel1_r    <= pop_idx_r;
            pop_idx_r <= grant_s;
            if (v1_r) begin
                data_out <= rd_word_s;
            end else begin
                data_out <= data_out;
            end
            if (state == ST_INIT) begin
                umbral_superior <= umbral_sup_in;
                umbral_inferior <= umbral_inf_in;
            end else begin
                umbral_superior <= umbral_superior;
                umbral_inferior <= umbral_inferior;
            end
            if (pop_ok_s && grant_vld_s) begin
                rr_ptr_r <= rr_nxt_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end
endmodule
